checksum_frame_ctrl: RTL
========================

Name: checksum_frame_ctrl

Overview:
- Frame sequencer in front of the PMU serial checksum engine.
- Accepts a serial bitstream frame of DATA_W payload bits followed by CHK_W checksum bits, both LSB-first.
- Clears and enables the checksum engine for exactly one frame, buffers the payload, and samples the engine's verdict.
- Releases the payload to the downstream loader only on a pass; on a fail, drops the frame, flags an error and counts it.

Parameters:
- DATA_W, 64: payload bits per frame.
- CHK_W, 8: checksum bits per frame.
- CHECK_LAT, 1: cycles from the last checksum bit accepted to a valid chk_ok_i.
- TIMEOUT_CYC, 255: maximum idle cycles inside a frame (optional feature only).

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- start_i, in, 1: begin a frame; honoured only in IDLE.
- bit_i, in, 1: serial frame bit.
- bit_valid_i, in, 1: bit_i is valid this cycle.
- ready_o, in→out, 1: output; high while in SHIFT, i.e. a bit is accepted when bit_valid_i && ready_o.
- chk_clr_o, out, 1: synchronous clear pulse to the checksum engine.
- chk_en_o, out, 1: checksum engine enable; equals bit_valid_i && ready_o.
- chk_bit_o, out, 1: data to the checksum engine; equals bit_i.
- chk_ok_i, in, 1: engine verdict; 1 = residue correct.
- payload_o, out, DATA_W: verified payload; bit 0 = first bit received.
- payload_valid_o, out, 1: payload_o valid.
- payload_ready_i, in, 1: downstream accepts payload.
- frame_err_o, out, 1: one-cycle pulse on checksum fail or timeout.
- err_cnt_o, out, 8: saturating count of failed frames.
- timeout_o, out, 1: one-cycle pulse on frame timeout.
- busy_o, out, 1: state != IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0, including payload_o, err_cnt_o and ready_o.
  - Reset mid-frame aborts immediately; no pulses are emitted.
- IDLE: start_i=1 → CLEAR. Bits presented in IDLE are ignored and not forwarded (chk_en_o=0).
- CLEAR, 1 cycle: chk_clr_o=1, bit counter=0 → SHIFT.
- SHIFT:
  - ready_o=1.
  - Each accepted bit increments the counter (width clog2(DATA_W+CHK_W+1)) and forwards to the engine.
  - While counter < DATA_W, the bit shifts into the payload buffer at index counter.
  - Checksum bits go only to the engine.
  - On accepting bit number DATA_W+CHK_W-1 (the last bit) → WAIT.
  - Gaps (bit_valid_i=0) stall without penalty.
- WAIT, CHECK_LAT cycles, then sample chk_ok_i:
  - chk_ok_i=1 → PASS.
  - chk_ok_i=0 → FAIL.
  - ready_o=0 in WAIT.
- PASS:
  - payload_valid_o=1; payload_o is stable until handshake.
  - payload_valid_o && payload_ready_i → IDLE next cycle.
  - payload_valid_o never drops without a handshake.
- FAIL, 1 cycle:
  - frame_err_o=1; err_cnt_o increments, saturating at 255; payload discarded → IDLE.
- start_i is ignored outside IDLE; a start_i held high across PASS→IDLE begins a new frame the cycle after IDLE is entered.
- Latency: last bit accepted → payload_valid_o = CHECK_LAT+1 cycles. start_i → first bit accepted ≥ 2 cycles.
- payload_o holds its last value in IDLE. It updates only while shifting.

Optional Feature:
- Macro: CHECKSUM_FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter runs in SHIFT and is cleared on every accepted bit.
  - Reaching TIMEOUT_CYC consecutive cycles without a bit → timeout_o=1 and frame_err_o=1 for one cycle, err_cnt_o increments, payload discarded → IDLE.
- Undefined: no counter; timeout_o tied 0; SHIFT waits indefinitely.

Decomposition:
- Package checksum_pkg:
  - State enum (IDLE, CLEAR, SHIFT, WAIT, PASS, FAIL).
  - Defaults DATA_W=64, CHK_W=8.
  - ERR_CNT_W=8.
- One natural sub-module, frame_bit_counter: bit count, last-bit detect, and optional idle timeout.
- The payload shift buffer stays in the top level.

Test Plan:
1. Good frame: rst_i pulse, start_i, 72 bits of payload 64'hA8D3F649C0CFA412 LSB-first then checksum 8'hFC, stub chk_ok_i=1 → chk_clr_o pulses once, exactly 72 chk_en_o cycles, payload_o=64'hA8D3F649C0CFA412, payload_valid_o CHECK_LAT+1 cycles after the last bit, err_cnt_o=0.
2. Corrupt frame: same frame with payload bit 0 flipped, chk_ok_i=0 → one frame_err_o pulse, err_cnt_o=1, payload_valid_o stays 0, return to IDLE.
3. Backpressure and gaps: random bit_valid_i gaps, payload_ready_i low for 10 cycles → payload_o stable, handshake completes, no extra chk_en_o pulses.
4. Reset mid-frame: rst_i asserted after 30 bits → all outputs 0 immediately; the next frame after reset passes cleanly.
5. Saturation: 260 failing frames → err_cnt_o=255.
6. With CHECKSUM_FRAME_TIMEOUT_EN, TIMEOUT_CYC=16: stop bits after 40 → timeout_o and frame_err_o pulse on idle cycle 16, state returns to IDLE. Without the macro, the same stimulus → busy_o stays 1.

Source files
------------

// File: rtl/checksum_pkg.sv
// Shared types, defaults and helpers for the checksum frame sequencer.
package checksum_pkg;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_CHK_W  = 8;
    localparam int unsigned ERR_CNT_W  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StWait,
        StPass,
        StFail
    } state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/checksum_frame_ctrl_if.sv
// Bit-stream, checksum-engine and payload signals of the frame sequencer.
interface checksum_frame_ctrl_if
    import checksum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic                 start_i;
    logic                 bit_i;
    logic                 bit_valid_i;
    logic                 ready_o;
    logic                 chk_clr_o;
    logic                 chk_en_o;
    logic                 chk_bit_o;
    logic                 chk_ok_i;
    logic [DATA_W-1:0]    payload_o;
    logic                 payload_valid_o;
    logic                 payload_ready_i;
    logic                 frame_err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;
    logic                 timeout_o;
    logic                 busy_o;

    modport master (
        output start_i, bit_i, bit_valid_i, chk_ok_i, payload_ready_i,
        input  ready_o, chk_clr_o, chk_en_o, chk_bit_o, payload_o, payload_valid_o,
        input  frame_err_o, err_cnt_o, timeout_o, busy_o
    );

    modport slave (
        input  start_i, bit_i, bit_valid_i, chk_ok_i, payload_ready_i,
        output ready_o, chk_clr_o, chk_en_o, chk_bit_o, payload_o, payload_valid_o,
        output frame_err_o, err_cnt_o, timeout_o, busy_o
    );

endinterface

// File: rtl/frame_bit_counter.sv
// Counts accepted frame bits and flags the last one; with CHECKSUM_FRAME_TIMEOUT_EN
// defined it also times out a frame that stalls inside SHIFT.
module frame_bit_counter #(
    parameter int unsigned TOTAL = 72,
    parameter int unsigned CNT_W = 7
`ifdef CHECKSUM_FRAME_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             active,
    input  logic             accept,
    output logic [CNT_W-1:0] count,
    output logic             last_bit,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count    = count_q;
    assign last_bit = active && accept && (count_q == LAST);

`ifdef CHECKSUM_FRAME_TIMEOUT_EN
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q <= '0;
        end else if (!active || accept) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + 1'b1;
        end
    end

    // Fires during the TIMEOUT_CYC-th consecutive empty cycle.
    assign timeout = active && !accept && (idle_q == IDLE_LAST);
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/checksum_frame_ctrl.sv
// Frame sequencer in front of the serial checksum engine. Optional frame timeout is
// enabled by defining CHECKSUM_FRAME_TIMEOUT_EN.
module checksum_frame_ctrl
    import checksum_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CHK_W       = DEF_CHK_W,
    parameter int unsigned CHECK_LAT   = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic                  clk_i,
    input logic                  rst_i,
    checksum_frame_ctrl_if.slave bus
);

    localparam int unsigned TOTAL  = DATA_W + CHK_W;
    localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
    localparam int unsigned PIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned WAIT_W = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

    localparam logic [CNT_W-1:0]  DATA_LIM  = CNT_W'(DATA_W);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CHECK_LAT - 1);

    if (CHECK_LAT < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("checksum_frame_ctrl: CHECK_LAT and TIMEOUT_CYC must be at least 1");
    end

    state_e               state_q;
    logic                 ready_q;
    logic                 clr_q;
    logic                 busy_q;
    logic                 valid_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [DATA_W-1:0]    payload_q;
`ifdef CHECKSUM_FRAME_TIMEOUT_EN
    logic                 tmo_q;
`endif

    logic              accept;
    logic              last_bit;
    logic              timeout;
    logic [CNT_W-1:0]  count;
    logic [PIDX_W-1:0] pidx;

    assign accept = bus.bit_valid_i && ready_q;
    assign pidx   = count[PIDX_W-1:0];

    frame_bit_counter #(
        .TOTAL       (TOTAL),
        .CNT_W       (CNT_W)
`ifdef CHECKSUM_FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
    ) u_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (state_q == StClear),
        .active   (ready_q),
        .accept   (accept),
        .count    (count),
        .last_bit (last_bit),
        .timeout  (timeout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            wait_q    <= '0;
            payload_q <= '0;
`ifdef CHECKSUM_FRAME_TIMEOUT_EN
            tmo_q     <= 1'b0;
`endif
        end else begin
            clr_q <= 1'b0;
            err_q <= 1'b0;
`ifdef CHECKSUM_FRAME_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            // Checksum bits (count >= DATA_W) reach only the engine.
            if (accept && (count < DATA_LIM)) begin
                payload_q[pidx] <= bus.bit_i;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        state_q <= StClear;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    state_q <= StShift;
                    ready_q <= 1'b1;
                end
                StShift: begin
                    if (timeout) begin
                        state_q   <= StFail;
                        ready_q   <= 1'b0;
                        err_q     <= 1'b1;
                        err_cnt_q <= sat_inc(err_cnt_q);
`ifdef CHECKSUM_FRAME_TIMEOUT_EN
                        tmo_q     <= 1'b1;
`endif
                    end else if (last_bit) begin
                        state_q <= StWait;
                        ready_q <= 1'b0;
                        wait_q  <= '0;
                    end
                end
                StWait: begin
                    if (wait_q == WAIT_LAST) begin
                        if (bus.chk_ok_i) begin
                            state_q <= StPass;
                            valid_q <= 1'b1;
                        end else begin
                            state_q   <= StFail;
                            err_q     <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StPass: begin
                    if (bus.payload_ready_i) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                StFail: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o         = ready_q;
    assign bus.chk_clr_o       = clr_q;
    assign bus.chk_en_o        = accept;
    assign bus.chk_bit_o       = bus.bit_i;
    assign bus.payload_o       = payload_q;
    assign bus.payload_valid_o = valid_q;
    assign bus.frame_err_o     = err_q;
    assign bus.err_cnt_o       = err_cnt_q;
    assign bus.busy_o          = busy_q;
`ifdef CHECKSUM_FRAME_TIMEOUT_EN
    assign bus.timeout_o       = tmo_q;
`else
    assign bus.timeout_o       = 1'b0;
`endif

endmodule
